// File: rtl/tile_addr_gen_pkg.sv
// Shared types and helpers for the tiled operand address generator.
package tile_addr_pkg;

    localparam int DEF_LANES  = 8;
    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DIM_W  = 12;
    localparam int LANE_SH    = $clog2(DEF_LANES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_COL  = 3'd1,
        OP_ADV  = 3'd2,
        OP_LOAD = 3'd3,
        OP_FIN  = 3'd4
    } lane_op_t;

    function automatic logic [31:0] ceil_div(input logic [31:0] n, input int sh);
        return (n + ((32'd1 << sh) - 32'd1)) >> sh;
    endfunction

    function automatic logic cfg_ok(input logic [31:0] m, input logic [31:0] k,
                                    input logic [31:0] ld);
        return (m != 32'd0) && (k != 32'd0) && (ld >= k);
    endfunction

endpackage

// File: rtl/tile_addr_gen_if.sv
// Controller-facing bundle: start/config/step in, lane addresses and status out.
interface tile_addr_gen_if #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 18,
    parameter int DIM_W  = 12
);
    logic                    start;
    logic [ADDR_W-1:0]       cfg_base;
    logic [DIM_W-1:0]        cfg_rows;
    logic [DIM_W-1:0]        cfg_cols;
    logic [DIM_W-1:0]        cfg_ld;
    logic [DIM_W-1:0]        cfg_passes;
    logic                    step_en;
    logic                    busy;
    logic [LANES*ADDR_W-1:0] addr_out;
    logic [LANES-1:0]        addr_valid;
    logic [DIM_W-1:0]        col_idx;
    logic [DIM_W-1:0]        tile_idx;
    logic [DIM_W-1:0]        pass_idx;
    logic                    tile_last_col;
    logic                    done;
    logic                    cfg_err;

    modport master (
        output start, cfg_base, cfg_rows, cfg_cols, cfg_ld, cfg_passes, step_en,
        input  busy, addr_out, addr_valid, col_idx, tile_idx, pass_idx,
               tile_last_col, done, cfg_err
    );

    modport slave (
        input  start, cfg_base, cfg_rows, cfg_cols, cfg_ld, cfg_passes, step_en,
        output busy, addr_out, addr_valid, col_idx, tile_idx, pass_idx,
               tile_last_col, done, cfg_err
    );
endinterface

// File: rtl/tile_addr_gen_lane.sv
// One address lane: row base register, column add and row-in-range valid flag.
module tile_addr_lane
    import tile_addr_pkg::*;
#(
    parameter int LANE_IDX = 0,
    parameter int LANES    = 8,
    parameter int ADDR_W   = 18,
    parameter int DIM_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  lane_op_t          op,
    input  logic [ADDR_W-1:0] base,
    input  logic [DIM_W-1:0]  ld,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  col_nx,
    input  logic [DIM_W-1:0]  tile_nx,
    output logic [ADDR_W-1:0] addr,
    output logic              valid
);
    localparam int LSH = $clog2(LANES);
    localparam int RW  = DIM_W + LSH + 1;

    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] ld_s;
    logic [ADDR_W-1:0] init_s;
    logic [ADDR_W-1:0] pitch_s;
    logic [RW-1:0]     row_s;

    // base + LANE_IDX*ld as a constant shift-add, plus tile pitch and row index
    always_comb begin
        ld_s   = ADDR_W'(ld);
        init_s = base;
        for (int b = 0; b < LSH; b++) begin
            init_s = init_s + ((((LANE_IDX >> b) & 1) != 0) ? (ld_s << b) : {ADDR_W{1'b0}});
        end
        pitch_s = ld_s << LSH;
        row_s   = (RW'(tile_nx) << LSH) + RW'(LANE_IDX);
    end

    // lane registers follow the operation chosen by the sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r <= {ADDR_W{1'b0}};
            addr   <= {ADDR_W{1'b0}};
            valid  <= 1'b0;
        end else begin
            case (op)
                OP_COL: begin
                    addr <= base_r + ADDR_W'(col_nx);
                end
                OP_ADV: begin
                    base_r <= base_r + pitch_s;
                    addr   <= base_r + pitch_s + ADDR_W'(col_nx);
                    valid  <= (row_s < RW'(m));
                end
                OP_LOAD: begin
                    base_r <= init_s;
                    addr   <= init_s + ADDR_W'(col_nx);
                    valid  <= (row_s < RW'(m));
                end
                OP_FIN: begin
                    valid <= 1'b0;
                end
                default: begin
                    base_r <= base_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/tile_addr_gen.sv
// Sweep sequencer: walks columns, row tiles and passes, driving LANES address lanes.
module tile_addr_gen
    import tile_addr_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W
) (
    input logic           clk,
    input logic           rst,
    tile_addr_gen_if.slave bus
);
    localparam int LSH = $clog2(LANES);
    localparam logic [DIM_W-1:0] ZERO = {DIM_W{1'b0}};
    localparam logic [DIM_W-1:0] ONE  = {{(DIM_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    logic [DIM_W-1:0]  ld_r, m_r, k_r, passes_r, nt_r;
    logic [DIM_W-1:0]  col_r, tile_r, pass_r;
    logic              busy_r, last_r, done_r, err_r;

    lane_op_t          op_s;
    logic [DIM_W-1:0]  col_nx_s, tile_nx_s, pass_nx_s;
    logic              start_ok_s, finish_s;
    logic [ADDR_W-1:0] lane_base_s;
    logic [DIM_W-1:0]  lane_ld_s, lane_m_s;
    logic [LANES*ADDR_W-1:0] addr_s;
    logic [LANES-1:0]  valid_s;

    // next indices and lane operation; on start the lanes see the raw config
    always_comb begin
        op_s        = OP_HOLD;
        col_nx_s    = col_r;
        tile_nx_s   = tile_r;
        pass_nx_s   = pass_r;
        finish_s    = 1'b0;
        lane_base_s = base_r;
        lane_ld_s   = ld_r;
        lane_m_s    = m_r;
        start_ok_s  = cfg_ok(32'(bus.cfg_rows), 32'(bus.cfg_cols), 32'(bus.cfg_ld));
        case (state_r)
            IDLE: begin
                if (bus.start && start_ok_s) begin
                    op_s        = OP_LOAD;
                    col_nx_s    = ZERO;
                    tile_nx_s   = ZERO;
                    pass_nx_s   = ZERO;
                    lane_base_s = bus.cfg_base;
                    lane_ld_s   = bus.cfg_ld;
                    lane_m_s    = bus.cfg_rows;
                end else begin
                    op_s = OP_HOLD;
                end
            end
            RUN: begin
                if (!bus.step_en) begin
                    op_s = OP_HOLD;
                end else if (col_r != k_r - ONE) begin
                    op_s     = OP_COL;
                    col_nx_s = col_r + ONE;
                end else if (tile_r != nt_r - ONE) begin
                    op_s      = OP_ADV;
                    col_nx_s  = ZERO;
                    tile_nx_s = tile_r + ONE;
                end else if (pass_r != passes_r - ONE) begin
                    op_s      = OP_LOAD;
                    col_nx_s  = ZERO;
                    tile_nx_s = ZERO;
                    pass_nx_s = pass_r + ONE;
                end else begin
                    op_s      = OP_FIN;
                    col_nx_s  = ZERO;
                    tile_nx_s = ZERO;
                    pass_nx_s = ZERO;
                    finish_s  = 1'b1;
                end
            end
            default: begin
                op_s = OP_HOLD;
            end
        endcase
    end

    // control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            base_r   <= {ADDR_W{1'b0}};
            ld_r     <= ZERO;
            m_r      <= ZERO;
            k_r      <= ZERO;
            passes_r <= ZERO;
            nt_r     <= ZERO;
            col_r    <= ZERO;
            tile_r   <= ZERO;
            pass_r   <= ZERO;
            busy_r   <= 1'b0;
            last_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start && start_ok_s) begin
                        state_r  <= RUN;
                        base_r   <= bus.cfg_base;
                        ld_r     <= bus.cfg_ld;
                        m_r      <= bus.cfg_rows;
                        k_r      <= bus.cfg_cols;
                        passes_r <= (bus.cfg_passes == ZERO) ? ONE : bus.cfg_passes;
                        nt_r     <= DIM_W'(ceil_div(32'(bus.cfg_rows), LSH));
                        col_r    <= ZERO;
                        tile_r   <= ZERO;
                        pass_r   <= ZERO;
                        busy_r   <= 1'b1;
                        last_r   <= (bus.cfg_cols == ONE);
                    end else if (bus.start) begin
                        err_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.step_en) begin
                        col_r  <= col_nx_s;
                        tile_r <= tile_nx_s;
                        pass_r <= pass_nx_s;
                        last_r <= (col_nx_s == k_r - ONE) && !finish_s;
                        if (finish_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tile_addr_lane #(
            .LANE_IDX (i),
            .LANES    (LANES),
            .ADDR_W   (ADDR_W),
            .DIM_W    (DIM_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .op      (op_s),
            .base    (lane_base_s),
            .ld      (lane_ld_s),
            .m       (lane_m_s),
            .col_nx  (col_nx_s),
            .tile_nx (tile_nx_s),
            .addr    (addr_s[i*ADDR_W +: ADDR_W]),
            .valid   (valid_s[i])
        );
    end

    assign bus.busy          = busy_r;
    assign bus.addr_out      = addr_s;
    assign bus.addr_valid    = valid_s;
    assign bus.col_idx       = col_r;
    assign bus.tile_idx      = tile_r;
    assign bus.pass_idx      = pass_r;
    assign bus.tile_last_col = last_r;
    assign bus.done          = done_r;
    assign bus.cfg_err       = err_r;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Directed bench for tile_addr_gen: table-driven two-pass sweep plus corner sequences.
module tb_tile_addr_gen;

    localparam int LANES = 8;
    localparam int AW    = 18;
    localparam int DW    = 12;

    typedef struct {
        int col;
        int tile;
        int pass;
        int lane0;
        int lane3;
        int valid;
        int last;
        int busy;
        int done;
        int chk_idx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_tot  = 0;
    vec_t tbl[19];

    always #5 clk = ~clk;

    tile_addr_gen_if #(.LANES(LANES), .ADDR_W(AW), .DIM_W(DW)) bus ();

    tile_addr_gen #(.LANES(LANES), .ADDR_W(AW), .DIM_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int lane(input int i);
        return int'(bus.addr_out[i*AW +: AW]);
    endfunction

    task automatic set_cfg(input int base, input int m, input int k, input int ld, input int p);
        bus.cfg_base   = AW'(base);
        bus.cfg_rows   = DW'(m);
        bus.cfg_cols   = DW'(k);
        bus.cfg_ld     = DW'(ld);
        bus.cfg_passes = DW'(p);
    endtask

    task automatic do_start(input int base, input int m, input int k, input int ld, input int p);
        set_cfg(base, m, k, ld, p);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic step1();
        bus.step_en = 1'b1;
        tick();
        bus.step_en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"},  int'(bus.busy), 0);
        chk({tag, " addr"},  int'(|bus.addr_out), 0);
        chk({tag, " valid"}, int'(bus.addr_valid), 0);
        chk({tag, " col"},   int'(bus.col_idx), 0);
        chk({tag, " tile"},  int'(bus.tile_idx), 0);
        chk({tag, " pass"},  int'(bus.pass_idx), 0);
        chk({tag, " last"},  int'(bus.tile_last_col), 0);
        chk({tag, " done"},  int'(bus.done), 0);
        chk({tag, " err"},   int'(bus.cfg_err), 0);
    endtask

    task automatic check_row(input int k);
        string p;
        p = $sformatf("row%0d", k);
        chk({p, " busy"},  int'(bus.busy), tbl[k].busy);
        chk({p, " done"},  int'(bus.done), tbl[k].done);
        chk({p, " valid"}, int'(bus.addr_valid), tbl[k].valid);
        chk({p, " lane0"}, lane(0), tbl[k].lane0);
        chk({p, " lane3"}, lane(3), tbl[k].lane3);
        chk({p, " last"},  int'(bus.tile_last_col), tbl[k].last);
        if (tbl[k].chk_idx != 0) begin
            chk({p, " col"},  int'(bus.col_idx), tbl[k].col);
            chk({p, " tile"}, int'(bus.tile_idx), tbl[k].tile);
            chk({p, " pass"}, int'(bus.pass_idx), tbl[k].pass);
        end
    endtask

    initial begin
        // base 0, M=20, K=3, ld=4, passes=2: state after k continuous steps
        //          col tile pass lane0 lane3 valid last busy done idx
        tbl[0]  = '{0, 0, 0,  0, 12, 255, 0, 1, 0, 1};
        tbl[1]  = '{1, 0, 0,  1, 13, 255, 0, 1, 0, 1};
        tbl[2]  = '{2, 0, 0,  2, 14, 255, 1, 1, 0, 1};
        tbl[3]  = '{0, 1, 0, 32, 44, 255, 0, 1, 0, 1};
        tbl[4]  = '{1, 1, 0, 33, 45, 255, 0, 1, 0, 1};
        tbl[5]  = '{2, 1, 0, 34, 46, 255, 1, 1, 0, 1};
        tbl[6]  = '{0, 2, 0, 64, 76,  15, 0, 1, 0, 1};
        tbl[7]  = '{1, 2, 0, 65, 77,  15, 0, 1, 0, 1};
        tbl[8]  = '{2, 2, 0, 66, 78,  15, 1, 1, 0, 1};
        tbl[9]  = '{0, 0, 1,  0, 12, 255, 0, 1, 0, 1};
        tbl[10] = '{1, 0, 1,  1, 13, 255, 0, 1, 0, 1};
        tbl[11] = '{2, 0, 1,  2, 14, 255, 1, 1, 0, 1};
        tbl[12] = '{0, 1, 1, 32, 44, 255, 0, 1, 0, 1};
        tbl[13] = '{1, 1, 1, 33, 45, 255, 0, 1, 0, 1};
        tbl[14] = '{2, 1, 1, 34, 46, 255, 1, 1, 0, 1};
        tbl[15] = '{0, 2, 1, 64, 76,  15, 0, 1, 0, 1};
        tbl[16] = '{1, 2, 1, 65, 77,  15, 0, 1, 0, 1};
        tbl[17] = '{2, 2, 1, 66, 78,  15, 1, 1, 0, 1};
        tbl[18] = '{0, 0, 0, 66, 78,   0, 0, 0, 1, 0};

        bus.start   = 1'b0;
        bus.step_en = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;

        // single pass: done on the 9th step
        do_start(0, 20, 3, 4, 1);
        chk("p1 start lane0", lane(0), 0);
        chk("p1 start lane7", lane(7), 28);
        chk("p1 start valid", int'(bus.addr_valid), 255);
        chk("p1 start busy", int'(bus.busy), 1);
        bus.step_en = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            tick();
            if (s == 3) begin
                chk("p1 s3 lane0", lane(0), 32);
                chk("p1 s3 tile", int'(bus.tile_idx), 1);
            end
            if (s == 6) begin
                chk("p1 s6 lane0", lane(0), 64);
                chk("p1 s6 lane3", lane(3), 76);
                chk("p1 s6 valid", int'(bus.addr_valid), 15);
            end
            if (s == 8) chk("p1 s8 done", int'(bus.done), 0);
        end
        bus.step_en = 1'b0;
        chk("p1 s9 done", int'(bus.done), 1);
        chk("p1 s9 busy", int'(bus.busy), 0);
        chk("p1 s9 valid", int'(bus.addr_valid), 0);
        tick();
        chk("p1 done pulse width", int'(bus.done), 0);

        // two passes, step_en held high the whole sweep
        do_start(0, 20, 3, 4, 2);
        check_row(0);
        bus.step_en = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            check_row(k);
        end
        bus.step_en = 1'b0;

        // rejected configurations
        do_start(0, 20, 5, 4, 1);
        chk("bad ld err", int'(bus.cfg_err), 1);
        chk("bad ld busy", int'(bus.busy), 0);
        tick();
        chk("bad ld err pulse", int'(bus.cfg_err), 0);
        chk("bad ld busy later", int'(bus.busy), 0);
        do_start(0, 0, 3, 4, 1);
        chk("m0 err", int'(bus.cfg_err), 1);
        chk("m0 busy", int'(bus.busy), 0);
        tick();
        chk("m0 err pulse", int'(bus.cfg_err), 0);

        // start and step together: the step is dropped
        bus.step_en = 1'b1;
        do_start(0, 20, 3, 4, 1);
        bus.step_en = 1'b0;
        chk("st+step busy", int'(bus.busy), 1);
        chk("st+step col", int'(bus.col_idx), 0);
        chk("st+step lane0", lane(0), 0);

        // start while busy is ignored
        do_start(100, 8, 2, 2, 1);
        chk("restart col", int'(bus.col_idx), 0);
        chk("restart tile", int'(bus.tile_idx), 0);
        chk("restart lane0", lane(0), 0);
        chk("restart lane3", lane(3), 12);
        chk("restart err", int'(bus.cfg_err), 0);

        // reset after four steps
        repeat (4) step1();
        chk("pre-rst col", int'(bus.col_idx), 1);
        chk("pre-rst tile", int'(bus.tile_idx), 1);
        chk("pre-rst lane0", lane(0), 33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("mid rst");
        do_start(0, 20, 3, 4, 1);
        chk("post-rst busy", int'(bus.busy), 1);
        chk("post-rst lane0", lane(0), 0);
        chk("post-rst lane3", lane(3), 12);
        chk("post-rst valid", int'(bus.addr_valid), 255);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // address wrap with passes=0 treated as one pass
        do_start(262142, 1, 4, 4, 0);
        chk("wrap a0", lane(0), 262142);
        chk("wrap valid", int'(bus.addr_valid), 1);
        chk("wrap last0", int'(bus.tile_last_col), 0);
        step1();
        chk("wrap a1", lane(0), 262143);
        step1();
        chk("wrap a2", lane(0), 0);
        chk("wrap last2", int'(bus.tile_last_col), 0);
        step1();
        chk("wrap a3", lane(0), 1);
        chk("wrap last3", int'(bus.tile_last_col), 1);
        step1();
        chk("wrap done", int'(bus.done), 1);
        chk("wrap busy", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
